dma_mem_model: RTL
==================

# dma_mem_model

Parametrised bus-side memory responder for the SDIO DMA testbench. It serves single-outstanding read/write requests from the DMA master with programmable latency, byte enables, a bounded address window with error response, and saturating transaction counters. It sits on the DMA bus between the SDIO host's DMA engine and the bench's backing store. The bench preloads and inspects the array hierarchically.

## Interface
Parameters:
- ADDR_W, 17: byte/word address width.
- DATA_W, 8: data width; must be a multiple of 8.
- MEM_DEPTH, 2**ADDR_W: number of words; addresses >= MEM_DEPTH are out of range.
- RD_LAT, 6: read latency in cycles, 1..15.
- WR_LAT, 6: write latency in cycles, 1..15.
- POISON, all-ones: read data returned for out-of-range reads.
- STALL_MAX, 3: maximum extra random stall cycles, 0..7 (used only with the macro).

Ports:
- bus_clk, in, 1: clock.
- rstn, in, 1: asynchronous, active-low reset.
- bus_rd, in, 1: read request.
- bus_wr, in, 1: write request.
- bus_addr, in, ADDR_W: request address.
- bus_wdata, in, DATA_W: write data.
- bus_be, in, DATA_W/8: write byte enables.
- bus_ready, out, 1: registered; accepts a request when high.
- bus_rdata_ready, out, 1: one-cycle pulse; read data valid.
- bus_rdata, out, DATA_W: read data.
- bus_err, out, 1: one-cycle pulse alongside a response; marks an errored transaction.
- rd_cnt, out, 16: completed reads, saturating.
- wr_cnt, out, 16: completed writes, saturating.
- err_cnt, out, 16: errored transactions, saturating.

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE: bus_ready=1.
  - On a posedge with exactly one of bus_rd/bus_wr high:
    - Latch addr, wdata, be, and direction.
    - Load the down-counter with LAT-1 (plus the stall value if enabled).
    - Go to BUSY; bus_ready falls at the same edge.
- BUSY: decrement each cycle. At the edge where the counter is 0, perform the access and go to RESP.
  - Write: each byte i with be[i]=1 is written. Out-of-range writes do not modify memory.
  - Read: the word at the latched address is loaded into bus_rdata, or POISON if out of range.
- RESP: lasts exactly one cycle.
  - bus_rdata_ready=1 for reads only; bus_err=1 if errored.
  - bus_ready=1, so a new request sampled in this cycle is accepted at the next edge (back-to-back).
  - Next state is BUSY if a request was accepted, otherwise IDLE.
- Requests are sampled from live bus signals only when bus_ready=1. Requests while bus_ready=0 are ignored.
- bus_rd and bus_wr high together: the request is accepted as an errored no-op.
  - It completes after RD_LAT.
  - bus_err pulses, err_cnt increments, and memory and bus_rdata are unchanged.
- Out-of-range access: completes normally with bus_err=1 and increments err_cnt. rd_cnt/wr_cnt are not incremented.
- Counters increment in the RESP cycle and saturate at 16'hFFFF.
- Addresses are not wrapped; any address >= MEM_DEPTH is an error.
- The memory array has no reset; the bench may preload it at any time via hierarchical access.

## Timing
- Request accepted at edge k:
  - Read: bus_rdata_ready and bus_rdata valid in the cycle after edge k+RD_LAT.
  - Write: memory updated at edge k+WR_LAT.
- bus_ready is low from edge k until edge k+LAT, and high again during the RESP cycle.
- Throughput is one transaction per LAT+1 cycles when requests are issued back-to-back.
- Reset values:
  - bus_ready=1, bus_rdata_ready=0, bus_err=0, bus_rdata=0, all counters 0, state IDLE.
- Reset mid-transaction: the pending access is dropped, no memory write occurs, and no response pulse is produced.

## Configuration
- DMA_MEM_STALL_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances each accepted request.
  - Its low 3 bits mod (STALL_MAX+1) are added to the latency of that transaction.
- DMA_MEM_STALL_EN undefined:
  - Latency is exactly RD_LAT/WR_LAT.
  - The LFSR is not instantiated and STALL_MAX is ignored.

## Test plan
- Write addr 0x00010 wdata 0xA5 be=1, then read 0x00010 → bus_rdata=0xA5 with bus_rdata_ready exactly RD_LAT+1 cycles after accept; wr_cnt=1, rd_cnt=1.
- DATA_W=32: preload 0x11223344, write 0xAABBCCDD with be=4'b0101, read back → 0x11BB33DD.
- Read addr MEM_DEPTH → bus_rdata=POISON, bus_err and bus_rdata_ready pulse together; err_cnt=1, rd_cnt=0.
- Assert bus_rd and bus_wr together on preloaded 0x5A → bus_err pulse after RD_LAT, memory still 0x5A.
- Deassert rstn two cycles after a write is accepted → memory unchanged, no response pulse, bus_ready=1 after reset.
- Issue 4 back-to-back reads with RD_LAT=3 → accepts spaced exactly 4 cycles apart; with DMA_MEM_STALL_EN, spacing stays within 4..4+STALL_MAX.

Source files
------------

// File: rtl/dma_mem_model_if.sv
// dma_mem_model_if: DMA bus request/response bundle between the DMA master and the memory responder.
interface dma_mem_model_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic                  bus_rd;
    logic                  bus_wr;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_be;
    logic                  bus_ready;
    logic                  bus_rdata_ready;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_err;

    modport master (
        output bus_rd, bus_wr, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata_ready, bus_rdata, bus_err
    );

    modport slave (
        input  bus_rd, bus_wr, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata_ready, bus_rdata, bus_err
    );
endinterface

// File: rtl/dma_mem_model.sv
// dma_mem_model: single-outstanding DMA memory responder with latency, byte enables, range errors, counters.
// Define DMA_MEM_STALL_EN to add LFSR-driven random stall cycles (0..STALL_MAX) per request.
module dma_mem_model #(
    parameter int              ADDR_W    = 17,
    parameter int              DATA_W    = 8,
    parameter int              MEM_DEPTH = 2**ADDR_W,
    parameter int              RD_LAT    = 6,
    parameter int              WR_LAT    = 6,
    parameter logic [DATA_W-1:0] POISON  = '1,
    parameter int              STALL_MAX = 3
) (
    input  logic              bus_clk,
    input  logic              rstn,
    dma_mem_model_if.slave    s_bus,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       err_cnt
);
    localparam int NB = DATA_W / 8;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    if (DATA_W % 8 != 0 || RD_LAT < 1 || RD_LAT > 15 || WR_LAT < 1 || WR_LAT > 15
        || STALL_MAX < 0 || STALL_MAX > 7) begin : g_bad_cfg
        $error("dma_mem_model: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e              state_q;
    logic [4:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;
    logic                rd_q, wr_q;
    logic                ready_q, rvalid_q, err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [15:0]         rd_cnt_q, wr_cnt_q, err_cnt_q;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic                accept, in_range, is_rd, is_wr, is_err, done;
    logic [IW-1:0]       idx;
    logic [4:0]          stall_d, lat_d;

    assign accept   = ready_q & (s_bus.bus_rd | s_bus.bus_wr);
    assign in_range = 64'(addr_q) < 64'(MEM_DEPTH);
    assign idx      = IW'(addr_q);
    assign is_rd    = rd_q & ~wr_q;
    assign is_wr    = wr_q & ~rd_q;
    assign is_err   = (rd_q & wr_q) | ~in_range;
    assign done     = (state_q == BUSY) && (cnt_q == 5'd0);
    // A simultaneous rd+wr takes the read latency.
    assign lat_d    = (s_bus.bus_rd ? 5'(RD_LAT - 1) : 5'(WR_LAT - 1)) + stall_d;

`ifdef DMA_MEM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign stall_d = 5'({1'b0, lfsr_d[2:0]} % 4'(STALL_MAX + 1));
    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) lfsr_q <= 16'hACE1;
        else if (accept) lfsr_q <= lfsr_d;
    end
`else
    assign stall_d = 5'd0;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v + {15'd0, ~&v};
    endfunction

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                BUSY: begin
                    if (cnt_q == 5'd0) begin
                        state_q  <= RESP;
                        ready_q  <= 1'b1;
                        rvalid_q <= is_rd;
                        err_q    <= is_err;
                        if (is_rd) rdata_q <= in_range ? mem[idx] : POISON;
                        if (is_err) err_cnt_q <= sat_inc(err_cnt_q);
                        else if (is_rd) rd_cnt_q <= sat_inc(rd_cnt_q);
                        else wr_cnt_q <= sat_inc(wr_cnt_q);
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        state_q <= BUSY;
                        ready_q <= 1'b0;
                        cnt_q   <= lat_d;
                        addr_q  <= s_bus.bus_addr;
                        wdata_q <= s_bus.bus_wdata;
                        be_q    <= s_bus.bus_be;
                        rd_q    <= s_bus.bus_rd;
                        wr_q    <= s_bus.bus_wr;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // No reset on the array; an aborted transaction never reaches done.
    always_ff @(posedge bus_clk) begin
        if (rstn && done && is_wr && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign s_bus.bus_ready       = ready_q;
    assign s_bus.bus_rdata_ready = rvalid_q;
    assign s_bus.bus_rdata       = rdata_q;
    assign s_bus.bus_err         = err_q;
    assign rd_cnt                = rd_cnt_q;
    assign wr_cnt                = wr_cnt_q;
    assign err_cnt               = err_cnt_q;
endmodule
